// File: rtl/ethernet_sys_descriptor_fetcher.sv
// Walks a linked chain of 4-word DMA descriptors, hands each owned one to the packet DMA and
// writes the completion status back. Optional chain-complete interrupt: DESC_FETCHER_IRQ_EN.
module ethernet_sys_descriptor_fetcher #(
   parameter int ADDR_W = 10,
   parameter int LEN_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_ptr,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic [1:0]        done_status,
   output logic [15:0]       desc_count,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [3:0]        mem_byteenable,
   output logic [31:0]       mem_writedata,
   input  logic [31:0]       mem_readdata,
   output logic              desc_valid,
   input  logic              desc_ready,
   output logic [31:0]       desc_addr,
   output logic [LEN_W-1:0]  desc_len,
   output logic              desc_last,
   input  logic              cpl_valid,
   input  logic [LEN_W-1:0]  cpl_len,
   input  logic              cpl_error,
   output logic              irq,
   input  logic              irq_clear
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_FETCH     = 3'd1;
   localparam logic [2:0] S_CHECK     = 3'd2;
   localparam logic [2:0] S_PRESENT   = 3'd3;
   localparam logic [2:0] S_WAIT_CPL  = 3'd4;
   localparam logic [2:0] S_WRITEBACK = 3'd5;
   localparam logic [2:0] S_NEXT      = 3'd6;

   logic [2:0]        state;
   logic [ADDR_W-1:0] ptr;
   logic [2:0]        k;
   logic [31:0]       word0;
   logic [LEN_W-1:0]  len_q;
   logic [ADDR_W-1:0] next_q;
   logic              owned;
   logic              last;
   logic              abort_pend;
   logic              abort_seen;
   logic [LEN_W-1:0]  cpl_len_q;
   logic              cpl_err_q;
   logic [31:0]       wb_data;

   assign abort_seen     = abort_pend | abort;
   assign busy           = (state != S_IDLE);
   assign desc_valid     = (state == S_PRESENT);
   assign desc_addr      = word0;
   assign desc_len       = len_q;
   assign desc_last      = last;
   assign mem_byteenable = 4'hF;

   always_comb begin
      wb_data              = '0;
      wb_data[31:28]       = {1'b0, last, 1'b1, cpl_err_q};
      wb_data[LEN_W-1:0]   = cpl_len_q;
   end

   // Reads are issued for k=0..3; k=4 only captures the data returned for k=3.
   always_comb begin
      mem_chipselect = 1'b0;
      mem_write      = 1'b0;
      mem_address    = '0;
      mem_writedata  = '0;
      if (state == S_FETCH && !k[2]) begin
         mem_chipselect = 1'b1;
         mem_address    = ptr + ADDR_W'(k[1:0]);
      end else if (state == S_WRITEBACK) begin
         mem_chipselect = 1'b1;
         mem_write      = 1'b1;
         mem_address    = ptr + ADDR_W'(3);
         mem_writedata  = wb_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         ptr         <= '0;
         k           <= '0;
         word0       <= '0;
         len_q       <= '0;
         next_q      <= '0;
         owned       <= 1'b0;
         last        <= 1'b0;
         abort_pend  <= 1'b0;
         cpl_len_q   <= '0;
         cpl_err_q   <= 1'b0;
         done        <= 1'b0;
         done_status <= 2'd0;
         desc_count  <= '0;
      end else begin
         done <= 1'b0;
         if (state != S_IDLE && abort)
            abort_pend <= 1'b1;
         case (state)
            S_IDLE: begin
               if (start) begin
                  ptr        <= start_ptr;
                  desc_count <= '0;
                  k          <= '0;
                  abort_pend <= 1'b0;
                  state      <= S_FETCH;
               end
            end
            S_FETCH: begin
               case (k)
                  3'd1: word0  <= mem_readdata;
                  3'd2: len_q  <= mem_readdata[LEN_W-1:0];
                  3'd3: next_q <= mem_readdata[ADDR_W-1:0];
                  3'd4: begin
                     owned <= mem_readdata[31];
                     last  <= mem_readdata[30];
                  end
                  default: ;
               endcase
               if (k == 3'd4)
                  state <= S_CHECK;
               else
                  k <= k + 3'd1;
            end
            S_CHECK: begin
               if (abort_seen || !owned) begin
                  state       <= S_IDLE;
                  done        <= 1'b1;
                  done_status <= abort_seen ? 2'd2 : 2'd1;
                  abort_pend  <= 1'b0;
               end else begin
                  state <= S_PRESENT;
               end
            end
            S_PRESENT: begin
               if (desc_ready)
                  state <= S_WAIT_CPL;
            end
            S_WAIT_CPL: begin
               if (cpl_valid) begin
                  cpl_len_q <= cpl_len;
                  cpl_err_q <= cpl_error;
                  state     <= S_WRITEBACK;
               end
            end
            S_WRITEBACK: begin
               if (desc_count != 16'hFFFF)
                  desc_count <= desc_count + 16'd1;
               state <= S_NEXT;
            end
            S_NEXT: begin
               if (last || abort_seen) begin
                  state       <= S_IDLE;
                  done        <= 1'b1;
                  done_status <= last ? 2'd0 : 2'd2;
                  abort_pend  <= 1'b0;
               end else begin
                  ptr   <= next_q;
                  k     <= '0;
                  state <= S_FETCH;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef DESC_FETCHER_IRQ_EN
   always_ff @(posedge clk) begin
      if (reset)
         irq <= 1'b0;
      else if (done)
         irq <= 1'b1;
      else if (irq_clear)
         irq <= 1'b0;
   end
`else
   logic unused_irq_clear;
   assign unused_irq_clear = irq_clear;
   assign irq              = 1'b0;
`endif

endmodule

// File: tb/tb_ethernet_sys_descriptor_fetcher.sv
// Self-checking bench for ethernet_sys_descriptor_fetcher: RAM model, transaction-level chain
// model and directed plus randomized chains.
module tb_ethernet_sys_descriptor_fetcher;
   localparam int AW = 10;
   localparam int LW = 16;

   logic clk = 1'b0;
   logic reset = 1'b1, start = 1'b0, abort = 1'b0, desc_ready = 1'b0;
   logic cpl_valid = 1'b0, cpl_error = 1'b0, irq_clear = 1'b0;
   logic [AW-1:0] start_ptr = '0;
   logic [LW-1:0] cpl_len = '0;
   logic [31:0]   mem_readdata;
   logic          busy, done, mem_chipselect, mem_write, desc_valid, desc_last, irq;
   logic [1:0]    done_status;
   logic [15:0]   desc_count;
   logic [AW-1:0] mem_address;
   logic [3:0]    mem_byteenable;
   logic [31:0]   mem_writedata, desc_addr;
   logic [LW-1:0] desc_len;

   ethernet_sys_descriptor_fetcher #(.ADDR_W(AW), .LEN_W(LW)) dut (
      .clk(clk), .reset(reset), .start(start), .start_ptr(start_ptr), .abort(abort),
      .busy(busy), .done(done), .done_status(done_status), .desc_count(desc_count),
      .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_write(mem_write),
      .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata),
      .mem_readdata(mem_readdata), .desc_valid(desc_valid), .desc_ready(desc_ready),
      .desc_addr(desc_addr), .desc_len(desc_len), .desc_last(desc_last),
      .cpl_valid(cpl_valid), .cpl_len(cpl_len), .cpl_error(cpl_error),
      .irq(irq), .irq_clear(irq_clear)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Descriptor RAM (1-cycle read latency) plus a bench-side shadow used by the model.
   logic [31:0] ram  [1024];
   logic [31:0] mref [1024];
   logic          ld_en = 1'b0;
   logic [AW-1:0] ld_a  = '0;
   logic [31:0]   ld_d  = '0;

   always @(posedge clk) begin
      if (ld_en)
         ram[ld_a] <= ld_d;
      else if (mem_chipselect && mem_write)
         ram[mem_address] <= mem_writedata;
      if (mem_chipselect && !mem_write)
         mem_readdata <= ram[mem_address];
   end

   // Observed transactions, only ever appended to by this monitor.
   logic [48:0] hs_q[$];
   logic [41:0] wr_q[$];
   logic [9:0]  rd_q[$];
   int          lat_q[$];
   int          done_cnt = 0;
   int          cyc_n = 0;
   int          last_cpl = 0;

   always @(negedge clk) begin
      cyc_n = cyc_n + 1;
      if (cpl_valid) last_cpl = cyc_n;
      if (done) done_cnt = done_cnt + 1;
      if (desc_valid && desc_ready) hs_q.push_back({desc_addr, desc_len, desc_last});
      if (mem_chipselect && mem_write) begin
         wr_q.push_back({mem_address, mem_writedata});
         lat_q.push_back(cyc_n - last_cpl);
      end
      if (mem_chipselect && !mem_write) rd_q.push_back(mem_address);
   end

   // Expected transactions.
   logic [48:0] exp_hs[$];
   logic [41:0] exp_wr[$];
   logic [9:0]  exp_rd[$];
   logic [16:0] cpl_q[$];
   logic [16:0] fix_q[$];
   logic [1:0]  exp_status;
   logic [15:0] exp_count;
   int hs_base, wr_base, rd_base, lat_base, t_valid, t_done, stab_bad;

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic load(input logic [9:0] a, input logic [31:0] d);
      ld_en = 1'b1; ld_a = a; ld_d = d; mref[a] = d;
      cyc();
      ld_en = 1'b0;
   endtask

   task automatic put_desc(input logic [9:0] p, input logic [31:0] ba, input logic [31:0] len,
                           input logic [31:0] nx, input logic [31:0] ctl);
      load(p, ba);
      load(p + 10'd1, len);
      load(p + 10'd2, nx);
      load(p + 10'd3, ctl);
   endtask

   // Transaction-level chain walk over the shadow memory; picks the completion for each owned
   // descriptor (fixed values from fix_q when provided) and predicts every bus transaction.
   task automatic model(input logic [9:0] sp);
      logic [9:0]  p;
      logic [31:0] w3, wd;
      logic [16:0] c;
      bit          fin;
      exp_hs.delete(); exp_wr.delete(); exp_rd.delete(); cpl_q.delete();
      p = sp; exp_count = '0; exp_status = 2'd0; fin = 0;
      for (int n = 0; n < 32 && !fin; n++) begin
         for (int k = 0; k < 4; k++) exp_rd.push_back(p + 10'(k));
         w3 = mref[p + 10'd3];
         if (!w3[31]) begin
            exp_status = 2'd1; fin = 1;
         end else begin
            exp_hs.push_back({mref[p], mref[p + 10'd1][15:0], w3[30]});
            if (fix_q.size() > 0) c = fix_q.pop_front();
            else c = {1'($urandom_range(0, 1)), 16'($urandom)};
            cpl_q.push_back(c);
            wd = {1'b0, w3[30], 1'b1, c[16], 12'h000, c[15:0]};
            exp_wr.push_back({p + 10'd3, wd});
            mref[p + 10'd3] = wd;
            if (exp_count != 16'hFFFF) exp_count++;
            if (w3[30]) begin
               exp_status = 2'd0; fin = 1;
            end else begin
               p = mref[p + 10'd2][9:0];
            end
         end
      end
   endtask

   // Drives one chain from start to done, acting as the DMA; bounded by a cycle budget.
   task automatic run(input logic [9:0] sp, input int first_rdy, input int maxrdy,
                      input int ab1, input int ab2, input bit stray);
      int rdy_wait, rdy_target, cpl_cnt;
      bit got, held;
      logic [48:0] snap;
      logic [16:0] c;
      hs_base = hs_q.size(); wr_base = wr_q.size(); rd_base = rd_q.size();
      lat_base = lat_q.size();
      t_valid = -1; t_done = -1; stab_bad = 0; held = 0; got = 0;
      rdy_wait = 0; rdy_target = first_rdy; cpl_cnt = -1; snap = '0;
      start_ptr = sp;
      for (int i = 0; i < 3000 && !got; i++) begin
         start = (i == 0);
         abort = (i == ab1) || (i == ab2);
         cpl_valid = 1'b0; cpl_error = 1'b0; cpl_len = '0;
         if (cpl_cnt == 0) begin
            c = (cpl_q.size() > 0) ? cpl_q.pop_front() : 17'h0;
            cpl_valid = 1'b1; cpl_error = c[16]; cpl_len = c[15:0];
            cpl_cnt = -1;
         end else if (cpl_cnt > 0) begin
            cpl_cnt--;
         end else if (stray && $urandom_range(0, 7) == 0) begin
            cpl_valid = 1'b1; cpl_error = 1'b1; cpl_len = 16'hBAD0;
         end
         desc_ready = 1'b0;
         if (desc_valid) begin
            if (t_valid < 0) t_valid = i;
            if (!held) begin
               held = 1; snap = {desc_addr, desc_len, desc_last};
            end else if ({desc_addr, desc_len, desc_last} !== snap) begin
               stab_bad++;
            end
            if (rdy_wait >= rdy_target) begin
               desc_ready = 1'b1; held = 0; rdy_wait = 0;
               rdy_target = $urandom_range(0, maxrdy);
               cpl_cnt = $urandom_range(1, 4);
            end else begin
               rdy_wait++;
            end
         end
         cyc();
         if (done) begin
            got = 1; t_done = i + 1;
         end
      end
      start = 1'b0; abort = 1'b0; desc_ready = 1'b0;
      cpl_valid = 1'b0; cpl_error = 1'b0;
      chk("chain_terminates", 64'(got), 64'd1);
   endtask

   task automatic cmp_all();
      int n;
      n = hs_q.size() - hs_base;
      chk("handshake_count", 64'(n), 64'(exp_hs.size()));
      for (int i = 0; i < n && i < exp_hs.size(); i++)
         chk("handshake", 64'(hs_q[hs_base + i]), 64'(exp_hs[i]));
      n = wr_q.size() - wr_base;
      chk("write_count", 64'(n), 64'(exp_wr.size()));
      for (int i = 0; i < n && i < exp_wr.size(); i++)
         chk("writeback", 64'(wr_q[wr_base + i]), 64'(exp_wr[i]));
      n = rd_q.size() - rd_base;
      chk("read_count", 64'(n), 64'(exp_rd.size()));
      for (int i = 0; i < n && i < exp_rd.size(); i++)
         chk("read_addr", 64'(rd_q[rd_base + i]), 64'(exp_rd[i]));
      chk("done_status", 64'(done_status), 64'(exp_status));
      chk("desc_count", 64'(desc_count), 64'(exp_count));
      chk("busy_at_done", 64'(busy), 64'd0);
   endtask

   initial begin
      int dc, wb, n, mode, r;
      logic [9:0] ptrs[5];
      logic [1:0] snap_status;
      logic [15:0] snap_count;

      // Reset state.
      repeat (3) cyc();
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_valid", 64'(desc_valid), 64'd0);
      chk("rst_strobes", 64'({mem_chipselect, mem_write}), 64'd0);
      chk("rst_count", 64'(desc_count), 64'd0);
      chk("rst_status", 64'(done_status), 64'd0);
      chk("rst_irq", 64'(irq), 64'd0);
      chk("byteenable", 64'(mem_byteenable), 64'hF);
      reset = 1'b0;
      cyc();

      // Two-descriptor chain, DMA always ready.
      put_desc(10'd0, 32'h1000, 32'd64, 32'd8, 32'h8000_0000);
      put_desc(10'd8, 32'h2000, 32'd128, 32'd0, 32'hC000_0000);
      fix_q.push_back({1'b0, 16'd64});
      fix_q.push_back({1'b0, 16'd100});
      model(10'd0);
      run(10'd0, 0, 0, -1, -1, 0);
      cmp_all();
      chk("start_to_valid", 64'(t_valid), 64'd7);
      if (wr_q.size() >= wr_base + 2) begin
         chk("wb_word3_at3", 64'(wr_q[wr_base]), 64'({10'd3, 32'h2000_0040}));
         chk("wb_word3_at11", 64'(wr_q[wr_base + 1]), 64'({10'd11, 32'h6000_0064}));
      end
      if (lat_q.size() >= lat_base + 2) begin
         chk("cpl_to_write_0", 64'(lat_q[lat_base]), 64'd1);
         chk("cpl_to_write_1", 64'(lat_q[lat_base + 1]), 64'd1);
      end

      // First descriptor not owned.
      put_desc(10'd5, 32'h5555, 32'd9, 32'd5, 32'h4000_0000);
      model(10'd5);
      run(10'd5, 0, 0, -1, -1, 0);
      cmp_all();
      chk("notowned_start_to_done", 64'(t_done), 64'd7);
      chk("notowned_no_valid", 64'(t_valid), 64'hFFFF_FFFF_FFFF_FFFF);

      // Descriptor wrapping past the top of the RAM.
      put_desc(10'd1022, 32'h3000, 32'd20, 32'd0, 32'hC000_0000);
      model(10'd1022);
      run(10'd1022, 1, 2, -1, -1, 0);
      cmp_all();
      if (rd_q.size() >= rd_base + 4)
         chk("wrap_reads", 64'({rd_q[rd_base], rd_q[rd_base + 1], rd_q[rd_base + 2],
                                rd_q[rd_base + 3]}), 64'({10'd1022, 10'd1023, 10'd0, 10'd1}));
      if (wr_q.size() >= wr_base + 1)
         chk("wrap_wb_addr", 64'(wr_q[wr_base][41:32]), 64'd1);

      // Abort pulses while the DMA stalls: transfer still completes, then stop as aborted.
      put_desc(10'd40, 32'h4000, 32'd32, 32'd60, 32'h8000_0000);
      put_desc(10'd60, 32'h6000, 32'd48, 32'd0, 32'hC000_0000);
      exp_hs.delete(); exp_wr.delete(); exp_rd.delete(); cpl_q.delete();
      exp_hs.push_back({32'h4000, 16'd32, 1'b0});
      exp_wr.push_back({10'd43, 32'h2000_0018});
      for (int k = 0; k < 4; k++) exp_rd.push_back(10'd40 + 10'(k));
      cpl_q.push_back({1'b0, 16'd24});
      exp_status = 2'd2; exp_count = 16'd1;
      run(10'd40, 10, 0, 9, 12, 0);
      cmp_all();
      chk("stall_desc_stable", 64'(stab_bad), 64'd0);

      // Reset while waiting for completion.
      put_desc(10'd200, 32'h7000, 32'd12, 32'd200, 32'hC000_0000);
      start_ptr = 10'd200; start = 1'b1;
      cyc();
      start = 1'b0;
      for (int i = 0; i < 20 && !desc_valid; i++) cyc();
      chk("rstwait_valid", 64'(desc_valid), 64'd1);
      desc_ready = 1'b1;
      cyc();
      desc_ready = 1'b0;
      chk("rstwait_in_wait", 64'({busy, desc_valid}), 64'b10);
      wb = wr_q.size(); dc = done_cnt;
      reset = 1'b1;
      cyc();
      chk("rstwait_busy", 64'(busy), 64'd0);
      chk("rstwait_desc_valid", 64'(desc_valid), 64'd0);
      chk("rstwait_status", 64'(done_status), 64'd0);
      reset = 1'b0;
      cyc();
      cpl_valid = 1'b1; cpl_len = 16'h0055;
      cyc();
      cpl_valid = 1'b0;
      repeat (4) cyc();
      chk("rstwait_no_write", 64'(wr_q.size()), 64'(wb));
      chk("rstwait_no_done", 64'(done_cnt), 64'(dc));
      chk("rstwait_idle", 64'(busy), 64'd0);
      mref[10'd203] = ram[10'd203];

      // Completion with error, chain continues.
      put_desc(10'd100, 32'h8000, 32'd16, 32'd104, 32'h8000_0000);
      put_desc(10'd104, 32'h9000, 32'd8, 32'd0, 32'hC000_0000);
      fix_q.push_back({1'b1, 16'd16});
      fix_q.push_back({1'b0, 16'd8});
      model(10'd100);
      run(10'd100, 0, 3, -1, -1, 0);
      cmp_all();
      if (wr_q.size() >= wr_base + 1)
         chk("err_wb_word3", 64'(wr_q[wr_base][31:0]), 64'h3000_0010);

      // Interrupt behaviour, including set and clear coinciding.
      cyc();
`ifdef DESC_FETCHER_IRQ_EN
      chk("irq_after_done", 64'(irq), 64'd1);
`else
      chk("irq_after_done", 64'(irq), 64'd0);
`endif
      irq_clear = 1'b1;
      cyc();
      chk("irq_cleared", 64'(irq), 64'd0);
      model(10'd5);
      run(10'd5, 0, 0, -1, -1, 0);
      cyc();
`ifdef DESC_FETCHER_IRQ_EN
      chk("irq_set_wins", 64'(irq), 64'd1);
`else
      chk("irq_set_wins", 64'(irq), 64'd0);
`endif
      cyc();
      chk("irq_clear_held", 64'(irq), 64'd0);
      irq_clear = 1'b0;

      // Randomized chains: end by LAST, by a not-owned descriptor, or by a self-loop.
      for (int it = 0; it < 8; it++) begin
         n = $urandom_range(1, 4);
         mode = $urandom_range(0, 2);
         for (int j = 0; j <= n; j++)
            ptrs[j] = 10'((128 + j * 10 + $urandom_range(0, 9)) * 4);
         for (int j = 0; j < n; j++) begin
            logic [31:0] ba, ln, nx, ctl;
            ba = $urandom;
            r = $urandom;
            ln = {r[31:16], 16'($urandom)};
            r = $urandom;
            nx = {r[31:10], ptrs[j + 1]};
            r = $urandom;
            ctl = {1'b1, 1'b0, r[29:0]};
            if (j == n - 1 && mode == 0) ctl[30] = 1'b1;
            if (j == n - 1 && mode == 2) nx[9:0] = ptrs[j];
            put_desc(ptrs[j], ba, ln, nx, ctl);
         end
         r = $urandom;
         if (mode == 1) put_desc(ptrs[n], $urandom, $urandom, $urandom, {1'b0, r[30:0]});
         model(ptrs[0]);
         snap_status = exp_status; snap_count = exp_count;
         run(ptrs[0], $urandom_range(0, 3), 3, -1, -1, 1);
         cmp_all();
         chk("rand_status", 64'(done_status), 64'(snap_status));
         chk("rand_count", 64'(desc_count), 64'(snap_count));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
